// File: rtl/access_controller.sv
// Door access controller: validates entered codes against a programmable table,
// holds the door unlocked for a fixed time, and locks out after repeated failures.
module access_controller #(
  parameter int CODE_W         = 12,
  parameter int NUM_CODES      = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int IW   = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1,
  localparam int FW   = $clog2(MAX_FAILS + 1),
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES,
  localparam int TW   = $clog2(TMAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_in,
  input  logic              prog_we,
  input  logic              prog_clr,
  input  logic [IW-1:0]     prog_idx,
  input  logic [CODE_W-1:0] prog_code,
  input  logic              emergency,
  output logic              door,
  output logic              code_ack,
  output logic              code_ok,
  output logic              locked_out,
  output logic              intrusion,
  output logic [FW-1:0]     fail_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_UNLOCK  = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;
  localparam logic [1:0] ST_EMERG   = 2'd3;

  logic [CODE_W-1:0] code_q [NUM_CODES];
  logic [NUM_CODES-1:0] valid_q;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic          door_q, door_d, ack_q, ack_d, ok_q, ok_d;
  logic          locked_q, locked_d, intr_q, intr_d;
  logic          match;

  // NOTE: only the valid bits are reset; the code storage needs no reset because
  // an entry is never compared until its valid bit has been set by a write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CODES; i++) begin
      if (prog_we && !prog_clr && prog_idx == IW'(i)) code_q[i] <= prog_code;
    end
  end

  // Indices at or above NUM_CODES match no entry, so such writes fall away.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CODES; i++) begin
        if (prog_we && prog_idx == IW'(i)) valid_q[i] <= !prog_clr;
      end
    end
  end

  // The table is registered, so a same-cycle write is not yet visible here.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (valid_q[i] && code_q[i] == code_in) match = 1'b1;
    end
  end

  assign fail_inc = fail_q + FW'(1);

  // NOTE: every signal assigned below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    ack_d   = 1'b0;
    ok_d    = 1'b0;
    intr_d  = 1'b0;
    if (emergency) begin
      state_d = ST_EMERG;
      timer_d = '0;
      fail_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (code_valid) begin
            ack_d = 1'b1;
            if (match) begin
              ok_d    = 1'b1;
              state_d = ST_UNLOCK;
              timer_d = TW'(UNLOCK_CYCLES);
              fail_d  = '0;
            end else if (fail_inc == FW'(MAX_FAILS)) begin
              state_d = ST_LOCKOUT;
              timer_d = TW'(LOCKOUT_CYCLES);
              fail_d  = '0;
              intr_d  = 1'b1;
            end else begin
              fail_d = fail_inc;
            end
          end
        end
        ST_UNLOCK, ST_LOCKOUT: begin
          if (timer_q <= TW'(1)) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_EMERG: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    door_d   = (state_d == ST_UNLOCK) || (state_d == ST_EMERG);
    locked_d = (state_d == ST_LOCKOUT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      fail_q   <= '0;
      door_q   <= 1'b0;
      ack_q    <= 1'b0;
      ok_q     <= 1'b0;
      locked_q <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      door_q   <= door_d;
      ack_q    <= ack_d;
      ok_q     <= ok_d;
      locked_q <= locked_d;
      intr_q   <= intr_d;
    end
  end

  assign door       = door_q;
  assign code_ack   = ack_q;
  assign code_ok    = ok_q;
  assign locked_out = locked_q;
  assign intrusion  = intr_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_access_controller.sv
// Directed bench for access_controller: unlock, failures, lockout, emergency,
// table edge cases and reset mid-operation. Uses 3 table entries so an
// out-of-range index is representable on the 2-bit prog_idx.
module tb_access_controller;

  localparam int CODE_W = 12;
  localparam int IW     = 2;
  localparam int FW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              code_valid;
  logic [CODE_W-1:0] code_in;
  logic              prog_we;
  logic              prog_clr;
  logic [IW-1:0]     prog_idx;
  logic [CODE_W-1:0] prog_code;
  logic              emergency;
  logic              door, code_ack, code_ok, locked_out, intrusion;
  logic [FW-1:0]     fail_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  always #5 clk = ~clk;

  access_controller #(.NUM_CODES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_in    (code_in),
    .prog_we    (prog_we),
    .prog_clr   (prog_clr),
    .prog_idx   (prog_idx),
    .prog_code  (prog_code),
    .emergency  (emergency),
    .door       (door),
    .code_ack   (code_ack),
    .code_ok    (code_ok),
    .locked_out (locked_out),
    .intrusion  (intrusion),
    .fail_cnt   (fail_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change after a falling edge; outputs are read at the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic prog(input int idx, input int code, input logic clr);
    prog_we   = 1'b1;
    prog_clr  = clr;
    prog_idx  = IW'(idx);
    prog_code = CODE_W'(code);
    step();
    prog_we  = 1'b0;
    prog_clr = 1'b0;
  endtask

  task automatic enter(input int code);
    code_valid = 1'b1;
    code_in    = CODE_W'(code);
    step();
    code_valid = 1'b0;
  endtask

  // Counts consecutive cycles, starting now, with door (which=0) or locked_out high.
  task automatic measure(input int which, output int n);
    n = 0;
    while (((which == 0) ? door : locked_out) && n < 64) begin
      n++;
      step();
    end
  endtask

  task automatic check_outputs(input string tag, input logic d, input logic a,
                               input logic o, input logic l, input logic i, input int f);
    check({tag, ".door"},   32'(door),       32'(d));
    check({tag, ".ack"},    32'(code_ack),   32'(a));
    check({tag, ".ok"},     32'(code_ok),    32'(o));
    check({tag, ".locked"}, 32'(locked_out), 32'(l));
    check({tag, ".intr"},   32'(intrusion),  32'(i));
    check({tag, ".fail"},   32'(fail_cnt),   32'(f));
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code_in = '0; prog_we = 1'b0; prog_clr = 1'b0;
    prog_idx = '0; prog_code = '0; emergency = 1'b0;
    step(); step();
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Basic unlock
    prog(0, 731, 1'b0);
    enter(731);
    check_outputs("unlock", 1, 1, 1, 0, 0, 0);
    measure(0, cnt);
    check("unlock.hold", 32'(cnt), 32'd8);
    check("unlock.after", 32'(door), 32'd0);

    // Failure then recovery
    prog(1, 294, 1'b0);
    enter(100);
    check_outputs("fail1", 0, 1, 0, 0, 0, 1);
    enter(294);
    check_outputs("recover", 1, 1, 1, 0, 0, 0);
    measure(0, cnt);
    check("recover.hold", 32'(cnt), 32'd8);

    // Lockout
    enter(5);
    check("lk.fail1", 32'(fail_cnt), 32'd1);
    enter(6);
    check("lk.fail2", 32'(fail_cnt), 32'd2);
    enter(7);
    check_outputs("lk.entry", 0, 1, 0, 1, 1, 0);
    step();
    check("lk.intr_once", 32'(intrusion), 32'd0);
    enter(731);
    check("lk.no_ack", 32'(code_ack), 32'd0);
    check("lk.fail_hold", 32'(fail_cnt), 32'd0);
    measure(1, cnt);
    check("lk.duration", 32'(2 + cnt), 32'd16);
    enter(731);
    check_outputs("lk.after", 1, 1, 1, 0, 0, 0);

    // Emergency held past the unlock time
    step(); step();
    emergency = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_outputs("em_unlock", 1, 0, 0, 0, 0, 0);
    emergency = 1'b0;
    step();
    check("em_unlock.exit_door", 32'(door), 32'd0);
    enter(731);
    check("em_unlock.idle_ok", 32'(code_ok), 32'd1);
    measure(0, cnt);

    // Emergency during lockout, lockout not resumed
    enter(11); enter(12); enter(13);
    check("em_lk.locked", 32'(locked_out), 32'd1);
    step(); step();
    emergency = 1'b1;
    step();
    check_outputs("em_lk", 1, 0, 0, 0, 0, 0);
    emergency = 1'b0;
    step();
    check_outputs("em_lk.exit", 0, 0, 0, 0, 0, 0);
    enter(1);
    check_outputs("em_lk.idle", 0, 1, 0, 0, 0, 1);

    // Emergency and code in the same cycle: code dropped, failures cleared
    emergency = 1'b1; code_valid = 1'b1; code_in = CODE_W'(731);
    step();
    emergency = 1'b0; code_valid = 1'b0;
    check_outputs("em_code", 1, 0, 0, 0, 0, 0);
    step();
    check("em_code.exit_door", 32'(door), 32'd0);

    // Table edge cases
    prog(0, 0, 1'b1);
    enter(731);
    check_outputs("tbl.cleared", 0, 1, 0, 0, 0, 1);
    enter(294);
    check("tbl.idx1_ok", 32'(code_ok), 32'd1);
    measure(0, cnt);
    prog(3, 555, 1'b0);
    enter(555);
    check_outputs("tbl.oob", 0, 1, 0, 0, 0, 1);
    prog_we = 1'b1; prog_idx = 2'd2; prog_code = CODE_W'(337);
    code_valid = 1'b1; code_in = CODE_W'(337);
    step();
    prog_we = 1'b0; code_valid = 1'b0;
    check_outputs("tbl.same_cycle", 0, 1, 0, 0, 0, 2);
    enter(337);
    check_outputs("tbl.next", 1, 1, 1, 0, 0, 0);

    // Reset mid-unlock
    step(); step();
    rst = 1'b1;
    step();
    check_outputs("rst_mid", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    enter(0);
    check_outputs("rst.zero_code", 0, 1, 0, 0, 0, 1);
    enter(294);
    check_outputs("rst.table_gone", 0, 1, 0, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
